// File: rtl/aoi_pkg.sv
// Shared types and golden model for AND-OR-INVERT cell checkers.
// The AOI function is y = ~((&a) | (|b)).
package aoi_pkg;

    // Widest cell (A_WIDTH + B_WIDTH) the golden function can evaluate.
    localparam int unsigned AOI_MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        CHECK  = 2'd2,
        FINISH = 2'd3
    } aoi_state_e;

    // Bits [a_width-1:0] of vec form the AND term.
    // Bits [n-1:a_width] are the single OR inputs.
    // Bits at n and above are ignored.
    function automatic logic aoi_golden(input logic [AOI_MAX_W-1:0] vec,
                                        input int unsigned          a_width,
                                        input int unsigned          n);
        logic and_t;
        logic or_t;
        and_t = 1'b1;
        or_t  = 1'b0;
        for (int unsigned i = 0; i < AOI_MAX_W; i++) begin
            if (i < a_width) begin
                and_t = and_t & vec[i];
            end else if (i < n) begin
                or_t = or_t | vec[i];
            end
        end
        return ~(and_t | or_t);
    endfunction

endpackage

// File: rtl/aoi_ref.sv
// Combinational golden AOI model.
// It is shared by the AOI sweep checker and by other cell checkers.
module aoi_ref
    import aoi_pkg::*;
#(
    parameter  int unsigned A_WIDTH = 2,
    parameter  int unsigned B_WIDTH = 1,
    localparam int unsigned N       = A_WIDTH + B_WIDTH
) (
    input  logic [N-1:0] vec_i,
    output logic         y_c
);

    assign y_c = aoi_golden(AOI_MAX_W'(vec_i), A_WIDTH, N);

endmodule

// File: rtl/aoi_sweep_checker.sv
// Exhaustive sweep engine for an external AOI cell.
// It drives every input vector, holds each one for SETTLE cycles, then checks the
// cell output against the golden model and accumulates the error statistics.
module aoi_sweep_checker
    import aoi_pkg::*;
#(
    parameter  int unsigned A_WIDTH = 2,
    parameter  int unsigned B_WIDTH = 1,
    parameter  int unsigned SETTLE  = 1,
    localparam int unsigned N       = A_WIDTH + B_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic [N-1:0] vec_o,
    input  logic         dut_y_i,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [N:0]   err_cnt,
    output logic [N-1:0] first_err_vec,
    output logic         first_err_valid
);

    localparam int unsigned CNT_W = $clog2(SETTLE + 1);
    localparam int unsigned ERR_W = N + 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);

    aoi_state_e       state_q, state_d;
    logic [N-1:0]     vec_q, vec_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [N-1:0]     fev_q, fev_d;
    logic             fv_q, fv_d;

    logic golden_y_c;
    logic mismatch_c;

    aoi_ref #(
        .A_WIDTH (A_WIDTH),
        .B_WIDTH (B_WIDTH)
    ) u_ref (
        .vec_i (vec_q),
        .y_c   (golden_y_c)
    );

    assign mismatch_c = (dut_y_i != golden_y_c);

    // Next-state and output logic.
    // busy, done and pass are computed together with the state so that they
    // are registered in step with it.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        err_d   = err_q;
        fev_d   = fev_q;
        fv_d    = fv_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DRIVE;
                    vec_d   = '0;
                    cnt_d   = '0;
                    err_d   = '0;
                    pass_d  = 1'b0;
                    fv_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end

            DRIVE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            CHECK: begin
                if (mismatch_c) begin
                    err_d = err_q + ERR_W'(1);
                    if (!fv_q) begin
                        fev_d = vec_q;
                        fv_d  = 1'b1;
                    end
                end

                // pass uses err_d so that an error found on the last vector counts.
                if (vec_q == '1) begin
                    state_d = FINISH;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0);
                end else begin
                    state_d = DRIVE;
                    vec_d   = vec_q + N'(1);
                    cnt_d   = '0;
                end
            end

            FINISH: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fev_q   <= '0;
            fv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fev_q   <= fev_d;
            fv_q    <= fv_d;
        end
    end

    assign vec_o           = vec_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign err_cnt         = err_q;
    assign first_err_vec   = fev_q;
    assign first_err_valid = fv_q;

    // busy and done are never high together.
    a_busy_done_excl: assert property (@(posedge clk) disable iff (rst)
        !(busy_q && done_q));

    // The error count never exceeds the number of vectors, 2^N.
    a_err_bound: assert property (@(posedge clk) disable iff (rst)
        err_q <= (ERR_W'(1) << N));

endmodule

// File: tb/tb_aoi_sweep_checker.sv
// Directed bench for aoi_sweep_checker.
// It runs an AOI21 instance (SETTLE=1) and an AOI211 instance (SETTLE=3).
module tb_aoi_sweep_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start0;
    logic start1;

    // AOI21 checker, SETTLE=1.
    logic [2:0] vec0;
    logic       y0;
    logic       good0;
    logic       busy0;
    logic       done0;
    logic       pass0;
    logic [3:0] err0;
    logic [2:0] fev0;
    logic       fv0;
    int         mode0;

    // AOI211 checker, SETTLE=3.
    logic [3:0] vec1;
    logic       y1;
    logic       busy1;
    logic       done1;
    logic       pass1;
    logic [4:0] err1;
    logic [3:0] fev1;
    logic       fv1;

    int n_vec  = 0;
    int n_miss = 0;

    // Cell models: mode 0 = correct, 1 = stuck-at-0, 2 = stuck-at-1, 3 = inverted output.
    assign good0 = ~((vec0[0] & vec0[1]) | vec0[2]);
    always_comb begin
        y0 = good0;
        case (mode0)
            1:       y0 = 1'b0;
            2:       y0 = 1'b1;
            3:       y0 = ~good0;
            default: y0 = good0;
        endcase
    end
    assign y1 = ~((vec1[0] & vec1[1]) | vec1[2] | vec1[3]);

    aoi_sweep_checker #(.A_WIDTH(2), .B_WIDTH(1), .SETTLE(1)) u_dut0 (
        .clk             (clk),
        .rst             (rst),
        .start           (start0),
        .vec_o           (vec0),
        .dut_y_i         (y0),
        .busy            (busy0),
        .done            (done0),
        .pass            (pass0),
        .err_cnt         (err0),
        .first_err_vec   (fev0),
        .first_err_valid (fv0)
    );

    aoi_sweep_checker #(.A_WIDTH(2), .B_WIDTH(2), .SETTLE(3)) u_dut1 (
        .clk             (clk),
        .rst             (rst),
        .start           (start1),
        .vec_o           (vec1),
        .dut_y_i         (y1),
        .busy            (busy1),
        .done            (done1),
        .pass            (pass1),
        .err_cnt         (err1),
        .first_err_vec   (fev1),
        .first_err_valid (fv1)
    );

    typedef struct {
        int mode;
        int exp_err;
        int exp_first;
        bit exp_valid;
        bit exp_pass;
    } sweep_vec_t;

    sweep_vec_t tbl[4];

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start0, then watch 40 cycles, counting busy cycles and done pulses.
    task automatic sweep0(output int busy_n, output int done_n);
        busy_n = 0;
        done_n = 0;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        check("start_vec0", vec0, 0);
        check("start_busy0", busy0, 1);
        for (int t = 0; t < 40; t++) begin
            if (busy0) busy_n++;
            if (done0) done_n++;
            tick();
        end
    endtask

    initial begin
        int busy_n;
        int done_n;
        int done_t[$];
        bit found;

        tbl[0] = '{mode: 0, exp_err: 0, exp_first: 0, exp_valid: 1'b0, exp_pass: 1'b1};
        tbl[1] = '{mode: 1, exp_err: 3, exp_first: 0, exp_valid: 1'b1, exp_pass: 1'b0};
        tbl[2] = '{mode: 2, exp_err: 5, exp_first: 3, exp_valid: 1'b1, exp_pass: 1'b0};
        tbl[3] = '{mode: 3, exp_err: 8, exp_first: 0, exp_valid: 1'b1, exp_pass: 1'b0};

        // Reset, with start held high at the same time: reset wins.
        rst    = 1'b1;
        start0 = 1'b1;
        start1 = 1'b1;
        mode0  = 0;
        repeat (3) tick();
        check("rst_busy0", busy0, 0);
        check("rst_vec0", vec0, 0);
        check("rst_done0", done0, 0);
        check("rst_pass0", pass0, 0);
        check("rst_err0", err0, 0);
        check("rst_fev0", fev0, 0);
        check("rst_fv0", fv0, 0);
        check("rst_busy1", busy1, 0);
        rst    = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        tick();
        check("idle_busy0", busy0, 0);

        // Table of AOI21 sweeps with different fault models.
        foreach (tbl[i]) begin
            mode0 = tbl[i].mode;
            sweep0(busy_n, done_n);
            check($sformatf("busy_cycles[%0d]", i), busy_n, 16);
            check($sformatf("done_pulses[%0d]", i), done_n, 1);
            check($sformatf("err_cnt[%0d]", i), err0, tbl[i].exp_err);
            check($sformatf("pass[%0d]", i), pass0, tbl[i].exp_pass);
            check($sformatf("first_valid[%0d]", i), fv0, tbl[i].exp_valid);
            if (tbl[i].exp_valid) begin
                check($sformatf("first_vec[%0d]", i), fev0, tbl[i].exp_first);
            end
        end

        // AOI211 with SETTLE=3; a second start during the sweep must be ignored.
        busy_n = 0;
        done_n = 0;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int t = 0; t < 90; t++) begin
            start1 = (t == 10);
            if (busy1) busy_n++;
            if (done1) done_n++;
            tick();
        end
        start1 = 1'b0;
        check("aoi211_busy", busy_n, 64);
        check("aoi211_done", done_n, 1);
        check("aoi211_pass", pass1, 1);
        check("aoi211_err", err1, 0);
        check("aoi211_fv", fv1, 0);

        // Reset at vector 5 of a sweep that has already counted errors.
        mode0  = 2;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        found  = 1'b0;
        for (int t = 0; t < 40 && !found; t++) begin
            if (vec0 == 3'd5) found = 1'b1;
            else tick();
        end
        check("reach_vec5", found, 1);
        check("mid_err", err0, 2);
        check("mid_fev", fev0, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_vec", vec0, 0);
        check("mrst_busy", busy0, 0);
        check("mrst_done", done0, 0);
        check("mrst_pass", pass0, 0);
        check("mrst_err", err0, 0);
        check("mrst_fev", fev0, 0);
        check("mrst_fv", fv0, 0);
        done_n = 0;
        for (int t = 0; t < 20; t++) begin
            if (done0 || busy0) done_n++;
            tick();
        end
        check("mrst_quiet", done_n, 0);
        mode0 = 0;
        sweep0(busy_n, done_n);
        check("post_rst_busy", busy_n, 16);
        check("post_rst_done", done_n, 1);
        check("post_rst_pass", pass0, 1);
        check("post_rst_err", err0, 0);

        // start held high: back-to-back sweeps, 18 cycles between the done pulses.
        mode0  = 2;
        start0 = 1'b1;
        for (int t = 0; t < 60 && done_t.size() < 2; t++) begin
            tick();
            if (done0) begin
                done_t.push_back(t);
                check("b2b_err_at_done", err0, 5);
                if (done_t.size() == 2) start0 = 1'b0;
            end
            if (done_t.size() == 1 && t == done_t[0] + 2) begin
                check("b2b_err_cleared", err0, 0);
                check("b2b_busy_second", busy0, 1);
            end
        end
        start0 = 1'b0;
        check("b2b_done_count", done_t.size(), 2);
        if (done_t.size() == 2) begin
            check("b2b_gap", done_t[1] - done_t[0], 18);
        end
        repeat (3) tick();
        check("b2b_idle_busy", busy0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
